// File: rtl/uart_cmd_pkg.sv
// Shared types, constants and the checksum helper for the UART command sequencer.
// Build option: UART_CMD_CHKSUM_EN adds a fourth, checksum byte to every frame.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

`ifdef UART_CMD_CHKSUM_EN
  localparam int CMD_BYTES = 4;
`else
  localparam int CMD_BYTES = 3;
`endif

  localparam int BYTE_CNT_W = 3;

  // Bytes buffered before the frame's final byte arrives.
  localparam int SHADOW_W = 8 * (CMD_BYTES - 1);

  // Checksum over the three payload bytes: bitwise inverse of their 8-bit sum.
  function automatic logic [7:0] chk_calc(input logic [7:0] b0,
                                          input logic [7:0] b1,
                                          input logic [7:0] b2);
    logic [7:0] sum;
    sum = b0 + b1 + b2;
    return ~sum;
  endfunction

endpackage

// File: rtl/uart_cmd_tmr.sv
// Inter-byte timeout counter. Counts up while enabled, clears on clr (clr wins),
// and flags expired once the count reaches TO_CYCLES-1.
module uart_cmd_tmr #(
  parameter int TO_CYCLES = 100000,
  parameter int TO_W      = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TO_CYCLES - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: collects bytes from the receiver into {opcode, data_hi, data_lo}
// commands, presents them on a cmd_rdy/clr_cmd_rdy handshake, drops partial frames on
// inter-byte timeout.
// Build option: UART_CMD_CHKSUM_EN -> 4-byte frames, last byte checked against chk_calc.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no partial frame; first accepted byte starts a frame
//   COLLECT | partial frame held in shadow; inter-byte timer running
//   HOLD    | cmd valid (cmd_rdy=1); receiver bytes left pending
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int TO_CYCLES = 100000,
  parameter int TO_W      = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frm_err,
  output logic        busy
);

  localparam logic [BYTE_CNT_W-1:0] LAST_CNT = BYTE_CNT_W'(CMD_BYTES - 1);

  state_t                 state_q, state_d;
  logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [SHADOW_W-1:0]    shadow_q, shadow_d;
  logic [23:0]            cmd_q, cmd_d;
  logic                   cmd_rdy_q, cmd_rdy_d;
  logic                   clr_rx_rdy_q, clr_rx_rdy_d;
  logic                   frm_err_q, frm_err_d;

  logic acc;
  logic tmr_en;
  logic tmr_clr;
  logic tmr_expired;

  // The registered clear blocks a second capture while the receiver drops rx_rdy;
  // in HOLD the byte is left pending so nothing is lost.
  assign acc = rx_rdy & ~clr_rx_rdy_q & (state_q != HOLD);

  // Timer runs only in COLLECT on cycles without a byte; any acceptance, leaving COLLECT
  // or the expiry itself restarts it from zero.
  assign tmr_en  = (state_q == COLLECT) & ~acc;
  assign tmr_clr = ~tmr_en | tmr_expired;

  uart_cmd_tmr #(
    .TO_CYCLES (TO_CYCLES),
    .TO_W      (TO_W)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Next-state, byte assembly, command load and error pulse.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shadow_d     = shadow_q;
    cmd_d        = cmd_q;
    cmd_rdy_d    = cmd_rdy_q;
    frm_err_d    = 1'b0;
    clr_rx_rdy_d = acc;

    unique case (state_q)
      IDLE: begin
        if (acc) begin
          shadow_d   = {shadow_q[SHADOW_W-9:0], rx_data};
          byte_cnt_d = BYTE_CNT_W'(1);
          state_d    = COLLECT;
        end
      end

      COLLECT: begin
        if (acc) begin
          if (byte_cnt_q == LAST_CNT) begin
            byte_cnt_d = '0;
`ifdef UART_CMD_CHKSUM_EN
            if (rx_data == chk_calc(shadow_q[23:16], shadow_q[15:8], shadow_q[7:0])) begin
              cmd_d     = shadow_q;
              cmd_rdy_d = 1'b1;
              state_d   = HOLD;
            end else begin
              frm_err_d = 1'b1;
              state_d   = IDLE;
            end
`else
            cmd_d     = {shadow_q, rx_data};
            cmd_rdy_d = 1'b1;
            state_d   = HOLD;
`endif
          end else begin
            shadow_d   = {shadow_q[SHADOW_W-9:0], rx_data};
            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
          end
        end else if (tmr_expired) begin
          frm_err_d  = 1'b1;
          byte_cnt_d = '0;
          state_d    = IDLE;
        end
      end

      HOLD: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        byte_cnt_d = '0;
        cmd_rdy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      shadow_q     <= '0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
      clr_rx_rdy_q <= 1'b0;
      frm_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shadow_q     <= shadow_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      frm_err_q    <= frm_err_d;
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign frm_err    = frm_err_q;
  assign busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed scenarios plus randomized frames and gaps, checked
// against a frame-level model (byte queue, gap-vs-timeout arithmetic, checksum sum).
module tb_uart_cmd_ctrl;

  localparam int TO_CYC = 16;
`ifdef UART_CMD_CHKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdy = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ferr_cyc = 0;
  int last_acc = 0;
  logic [7:0]  fq[$];
  logic [23:0] exp_cmd = 24'h0;
  bit          holding = 1'b0;

  uart_cmd_ctrl #(
    .TO_CYCLES (TO_CYC),
    .TO_W      (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .frm_err     (frm_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (frm_err === 1'b1) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
  endtask

  function automatic logic [7:0] sum_chk(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
    logic [7:0] s;
    s = a + b + c;
    return 8'hFF - s;
  endfunction

  // Wait gap idle cycles, then offer one byte. Accepts are gap+2 edges apart, so the partial
  // frame must time out exactly when that distance exceeds TO_CYC.
  task automatic put_byte(input logic [7:0] b, input int gap);
    int n;
    bit exp_err;
    bit ok;
    exp_err = (fq.size() > 0) && (gap + 2 > TO_CYC);
    ferr_cnt = 0;
    repeat (gap) tick();
    chk("timeout_pulses", ferr_cnt, exp_err);
    if (exp_err) begin
      chk("timeout_at", ferr_cyc - last_acc, TO_CYC);
      chk("timeout_busy", busy, 0);
      fq.delete();
    end
    rx_data = b;
    rx_rdy  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (clr_rx_rdy !== 1'b1 && n < 40);
    rx_rdy = 1'b0;
    chk("acc_latency", n, 1);
    last_acc = cyc;
    fq.push_back(b);
    if (fq.size() == NB) begin
      ok = 1'b1;
`ifdef UART_CMD_CHKSUM_EN
      ok = (fq[3] == sum_chk(fq[0], fq[1], fq[2]));
`endif
      if (ok) begin
        exp_cmd = {fq[0], fq[1], fq[2]};
        holding = 1'b1;
      end
      chk("frame_cmd_rdy", cmd_rdy, ok);
      chk("frame_frm_err", frm_err, !ok);
      chk("frame_cmd", cmd, exp_cmd);
      fq.delete();
    end else begin
      chk("partial_busy", busy, 1);
      chk("partial_cmd_rdy", cmd_rdy, 0);
      chk("partial_cmd", cmd, exp_cmd);
    end
    tick();
    chk("clr_pulse_1clk", clr_rx_rdy, 0);
    chk("frm_err_1clk", frm_err, 0);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int g0, input int g);
    put_byte(b0, g0);
    put_byte(b1, g);
    put_byte(b2, g);
`ifdef UART_CMD_CHKSUM_EN
    put_byte(sum_chk(b0, b1, b2), g);
`endif
  endtask

  task automatic release_cmd();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("release_cmd_rdy", cmd_rdy, 0);
    chk("release_cmd_held", cmd, exp_cmd);
    chk("release_busy", busy, 0);
    holding = 1'b0;
  endtask

  task automatic reset_with_pending();
    rx_data = 8'hEE;
    rx_rdy  = 1'b1;
    rst     = 1'b1;
    tick();
    chk("rst_clr_rx_rdy", clr_rx_rdy, 0);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_frm_err", frm_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", cmd, 0);
    rst    = 1'b0;
    rx_rdy = 1'b0;
    fq.delete();
    exp_cmd = 24'h0;
    holding = 1'b0;
  endtask

  initial begin
    int n;
    int g;
    int guard;
    logic [7:0] b;
    int gaps[8];
    gaps = '{0, 1, 2, 5, 13, 14, 15, 22};

    // power-up reset
    rst = 1'b1;
    repeat (2) tick();
    chk("init_cmd", cmd, 0);
    chk("init_cmd_rdy", cmd_rdy, 0);
    chk("init_clr_rx_rdy", clr_rx_rdy, 0);
    chk("init_frm_err", frm_err, 0);
    chk("init_busy", busy, 0);
    rst = 1'b0;
    tick();

    // nominal frame
    send_frame(8'hA5, 8'h12, 8'h34, 0, 1);
    chk("nominal_cmd", cmd, 24'hA51234);

    // byte arriving during HOLD stays pending, taken in the first IDLE cycle
    rx_data = 8'h77;
    rx_rdy  = 1'b1;
    n = 0;
    repeat (5) begin
      tick();
      if (clr_rx_rdy === 1'b1) n++;
    end
    chk("hold_no_clr_rx_rdy", n, 0);
    chk("hold_cmd_rdy", cmd_rdy, 1);
    chk("hold_cmd_kept", cmd, 24'hA51234);
    release_cmd();
    tick();
    chk("pend_acc_first_idle", clr_rx_rdy, 1);
    chk("pend_busy", busy, 1);
    rx_rdy = 1'b0;
    last_acc = cyc;
    fq.push_back(8'h77);
    tick();
    chk("pend_clr_1clk", clr_rx_rdy, 0);
    put_byte(8'h88, 0);
    put_byte(8'h99, 0);
`ifdef UART_CMD_CHKSUM_EN
    put_byte(sum_chk(8'h77, 8'h88, 8'h99), 0);
`endif
    chk("hold_next_cmd", cmd, 24'h778899);
    release_cmd();

    // reset in the middle of a frame discards the partial byte
    put_byte(8'h5A, 0);
    reset_with_pending();
    send_frame(8'h01, 8'hC0, 8'hDE, 0, 0);
    chk("post_rst_cmd", cmd, 24'h01C0DE);
    release_cmd();

    // timeout after one byte, then a clean frame
    put_byte(8'h01, 0);
    send_frame(8'hC3, 8'h3C, 8'hE7, 15, 0);
    chk("post_timeout_cmd", cmd, 24'hC33CE7);
    release_cmd();

    // byte landing on the last timer count is accepted
    send_frame(8'h11, 8'h22, 8'h33, 0, 14);
    chk("boundary_cmd", cmd, 24'h112233);
    release_cmd();

`ifdef UART_CMD_CHKSUM_EN
    // checksum good / bad
    put_byte(8'h10, 0);
    put_byte(8'h20, 0);
    put_byte(8'h30, 0);
    put_byte(8'h9F, 0);
    chk("chk_good_cmd", cmd, 24'h102030);
    release_cmd();
    put_byte(8'h10, 0);
    put_byte(8'h20, 0);
    put_byte(8'h30, 0);
    put_byte(8'h00, 0);
    chk("chk_bad_cmd_rdy", cmd_rdy, 0);
    chk("chk_bad_cmd", cmd, 24'h102030);
`endif

    // randomized frames and gaps
    for (int f = 0; f < 30; f++) begin
      guard = 0;
      while (!holding && guard < 16) begin
        g = gaps[$urandom_range(0, 7)];
        b = 8'($urandom);
`ifdef UART_CMD_CHKSUM_EN
        if (fq.size() == NB - 1 && $urandom_range(0, 3) != 0) b = sum_chk(fq[0], fq[1], fq[2]);
`endif
        put_byte(b, g);
        guard++;
      end
      if (holding) begin
        repeat ($urandom_range(0, 3)) tick();
        chk("rand_hold_cmd_rdy", cmd_rdy, 1);
        release_cmd();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
